// File: rtl/game_pkg.sv
// Shared game types: directions, tile kinds, map geometry and player start tiles.
`timescale 1ns/1ps
package game_pkg;

   typedef enum logic [2:0] {
      WAIT  = 3'd0,
      RIGHT = 3'd1,
      LEFT  = 3'd2,
      DOWN  = 3'd3,
      UP    = 3'd4
   } dir_t;

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      WALL  = 2'd1,
      BOX   = 2'd2,
      GOAL  = 2'd3
   } tile_t;

   localparam int unsigned MAP_WIDTH  = 16;
   localparam int unsigned MAP_HEIGHT = 16;

   localparam logic [7:0] X_LAST = 8'(MAP_WIDTH - 1);
   localparam logic [7:0] Y_LAST = 8'(MAP_HEIGHT - 1);

   localparam logic [7:0] start_x_1 = 8'd1;
   localparam logic [7:0] start_y_1 = 8'd1;
   localparam logic [7:0] start_x_2 = 8'd3;
   localparam logic [7:0] start_y_2 = 8'd1;

endpackage

// File: rtl/move_cooldown.sv
// Per-player move cooldown: load MOVE_PERIOD-1, count down to zero and hold.
`timescale 1ns/1ps
module move_cooldown #(
   parameter int unsigned MOVE_PERIOD = 16_250_000
) (
   input  logic clk,
   input  logic rst,
   input  logic load,
   output logic zero
);

   localparam int unsigned W = (MOVE_PERIOD > 1) ? $clog2(MOVE_PERIOD) : 1;

   logic [W-1:0] count;

   always_ff @(posedge clk) begin
      if (rst)
         count <= '0;
      else if (load)
         count <= W'(MOVE_PERIOD - 1);
      else if (count != '0)
         count <= count - W'(1);
   end

   assign zero = (count == '0);

endmodule

// File: rtl/move_arbiter.sv
// Two-player move arbiter sharing one map read port; round-robin grant, per-player cooldown.
// Define MOVE_ARB_WRAP_EN to make edge moves wrap around instead of blocking.
`timescale 1ns/1ps
module move_arbiter
   import game_pkg::*;
#(
   parameter int unsigned MOVE_PERIOD = 16_250_000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       req_1,
   input  logic       req_2,
   input  dir_t       dir_1,
   input  dir_t       dir_2,
   output logic       map_rd_en,
   output logic [7:0] map_rd_x,
   output logic [7:0] map_rd_y,
   input  tile_t      map_rd_data,
   output logic       ack_1,
   output logic       ack_2,
   output logic       blocked_1,
   output logic       blocked_2,
   output logic [7:0] pos_x_1,
   output logic [7:0] pos_y_1,
   output logic [7:0] pos_x_2,
   output logic [7:0] pos_y_2,
   output logic       busy
);

   typedef enum logic [1:0] {IDLE, ADDR, DATA, DONE} state_t;

   state_t     state, state_nxt;
   logic       gnt, rr_ptr, gnt_sel;
   dir_t       dir_g;
   logic       elig_1, elig_2, cd_zero_1, cd_zero_2;
   logic [7:0] cur_x, cur_y, oth_x, oth_y, tgt_x, tgt_y;
   logic       oob, skip, res_blk, move_ok, load_1, load_2;

   assign elig_1  = req_1 & cd_zero_1;
   assign elig_2  = req_2 & cd_zero_2;
   assign gnt_sel = (elig_1 & elig_2) ? rr_ptr : elig_2;

   assign cur_x = gnt ? pos_x_2 : pos_x_1;
   assign cur_y = gnt ? pos_y_2 : pos_y_1;
   assign oth_x = gnt ? pos_x_1 : pos_x_2;
   assign oth_y = gnt ? pos_y_1 : pos_y_2;

   // Underflow at 0 lands above the last column/row, so one compare covers both edges.
   always_comb begin
      tgt_x = cur_x;
      tgt_y = cur_y;
      oob   = 1'b0;
      case (dir_g)
         RIGHT:   tgt_x = cur_x + 8'd1;
         LEFT:    tgt_x = cur_x - 8'd1;
         DOWN:    tgt_y = cur_y + 8'd1;
         UP:      tgt_y = cur_y - 8'd1;
         default: ;
      endcase
`ifdef MOVE_ARB_WRAP_EN
      if (tgt_x > X_LAST) tgt_x = (dir_g == LEFT) ? X_LAST : '0;
      if (tgt_y > Y_LAST) tgt_y = (dir_g == UP) ? Y_LAST : '0;
`else
      oob = (tgt_x > X_LAST) || (tgt_y > Y_LAST);
`endif
   end

   assign skip    = (dir_g == WAIT) || oob;
   assign res_blk = (state == DATA) ?
                    ((map_rd_data != EMPTY) || ({tgt_x, tgt_y} == {oth_x, oth_y})) : oob;
   assign move_ok = (state == DONE) && !(gnt ? blocked_2 : blocked_1) && (dir_g != WAIT);
   assign load_1  = move_ok & ~gnt;
   assign load_2  = move_ok &  gnt;

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (elig_1 | elig_2) state_nxt = ADDR;
         ADDR:    state_nxt = skip ? DONE : DATA;
         DATA:    state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      busy      = (state != IDLE);
      map_rd_en = (state == ADDR) && !skip;
      map_rd_x  = tgt_x;
      map_rd_y  = tgt_y;
      ack_1     = (state == DONE) && !gnt;
      ack_2     = (state == DONE) &&  gnt;
   end

   // Result lands in the edge entering DONE so blocked_N is valid alongside ack_N.
   always_ff @(posedge clk) begin
      if (rst) begin
         gnt       <= 1'b0;
         rr_ptr    <= 1'b0;
         dir_g     <= WAIT;
         blocked_1 <= 1'b0;
         blocked_2 <= 1'b0;
         pos_x_1   <= start_x_1;
         pos_y_1   <= start_y_1;
         pos_x_2   <= start_x_2;
         pos_y_2   <= start_y_2;
      end else begin
         if (state == IDLE && (elig_1 | elig_2)) begin
            gnt    <= gnt_sel;
            rr_ptr <= ~gnt_sel;
            dir_g  <= gnt_sel ? dir_2 : dir_1;
         end
         if ((state == ADDR && skip) || state == DATA) begin
            if (gnt) blocked_2 <= res_blk;
            else     blocked_1 <= res_blk;
         end
         if (load_1) begin
            pos_x_1 <= tgt_x;
            pos_y_1 <= tgt_y;
         end
         if (load_2) begin
            pos_x_2 <= tgt_x;
            pos_y_2 <= tgt_y;
         end
      end
   end

   move_cooldown #(.MOVE_PERIOD(MOVE_PERIOD)) u_cd_1 (
      .clk  (clk),
      .rst  (rst),
      .load (load_1),
      .zero (cd_zero_1)
   );

   move_cooldown #(.MOVE_PERIOD(MOVE_PERIOD)) u_cd_2 (
      .clk  (clk),
      .rst  (rst),
      .load (load_2),
      .zero (cd_zero_2)
   );

endmodule

// File: tb/tb_move_arbiter.sv
// Bench for move_arbiter: directed scenarios plus random traffic against a transaction-level model.
`timescale 1ns/1ps
module tb_move_arbiter;
   import game_pkg::*;

   localparam int unsigned MP = 4;

   logic       clk = 1'b0, rst = 1'b1, req_1 = 1'b0, req_2 = 1'b0;
   dir_t       dir_1 = WAIT, dir_2 = WAIT;
   logic       map_rd_en;
   logic [7:0] map_rd_x, map_rd_y;
   tile_t      map_rd_data = EMPTY;
   logic       ack_1, ack_2, blocked_1, blocked_2, busy;
   logic [7:0] pos_x_1, pos_y_1, pos_x_2, pos_y_2;

   move_arbiter #(.MOVE_PERIOD(MP)) dut (
      .clk(clk), .rst(rst), .req_1(req_1), .req_2(req_2), .dir_1(dir_1), .dir_2(dir_2),
      .map_rd_en(map_rd_en), .map_rd_x(map_rd_x), .map_rd_y(map_rd_y), .map_rd_data(map_rd_data),
      .ack_1(ack_1), .ack_2(ack_2), .blocked_1(blocked_1), .blocked_2(blocked_2),
      .pos_x_1(pos_x_1), .pos_y_1(pos_y_1), .pos_x_2(pos_x_2), .pos_y_2(pos_y_2), .busy(busy)
   );

   always #5 clk = ~clk;

   tile_t map_mem [MAP_HEIGHT][MAP_WIDTH];

   always @(posedge clk)
      if (map_rd_en) map_rd_data <= map_mem[int'(map_rd_y) % MAP_HEIGHT][int'(map_rd_x) % MAP_WIDTH];

   int n_cmp = 0, n_err = 0, cyc = 0;
   bit cmp_en = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   // Stimulus state and reference model (one transaction tracked at a time).
   bit   rst_v;
   bit   rq [2];
   dir_t rd [2];
   int   m_x [2], m_y [2], m_ready [2];
   int   m_ptr, m_g, m_ack, m_own, m_tx, m_ty;
   bit   m_busy, m_read, m_blk, m_move;
   bit   e_blk [2], e_ack [2], o_ack [2];

   task automatic model_reset();
      m_x[0] = start_x_1; m_y[0] = start_y_1;
      m_x[1] = start_x_2; m_y[1] = start_y_2;
      m_ready = '{0, 0};
      m_ptr = 0; m_busy = 0;
      e_blk = '{0, 0};
   endtask

   task automatic predict(input int p);
      int o, nx, ny, w, h;
      o = 1 - p; nx = m_x[p]; ny = m_y[p];
      w = int'(MAP_WIDTH); h = int'(MAP_HEIGHT);
      case (rd[p])
         RIGHT: nx++;
         LEFT:  nx--;
         DOWN:  ny++;
         UP:    ny--;
         default: ;
      endcase
      m_own = p; m_read = 0; m_blk = 0; m_move = 0;
      if (rd[p] != WAIT) begin
         if (nx < 0 || ny < 0 || nx >= w || ny >= h) begin
`ifdef MOVE_ARB_WRAP_EN
            nx = (nx + w) % w; ny = (ny + h) % h;
            m_read = 1;
`else
            m_blk = 1;
`endif
         end else
            m_read = 1;
         if (m_read) begin
            m_blk  = (map_mem[ny][nx] != EMPTY) || (nx == m_x[o] && ny == m_y[o]);
            m_move = !m_blk;
         end
      end
      m_tx = nx; m_ty = ny;
   endtask

   task automatic step();
      bit e0, e1;
      int p;
      @(posedge clk); #1;
      cyc++;
      rst = rst_v; req_1 = rq[0]; req_2 = rq[1]; dir_1 = rd[0]; dir_2 = rd[1];
      if (!m_busy && !rst_v) begin
         e0 = rq[0] && cyc >= m_ready[0];
         e1 = rq[1] && cyc >= m_ready[1];
         if (e0 || e1) begin
            p = (e0 && e1) ? m_ptr : (e1 ? 1 : 0);
            m_ptr = 1 - p;
            predict(p);
            m_busy = 1; m_g = cyc; m_ack = cyc + (m_read ? 3 : 2);
         end
      end
      for (int i = 0; i < 2; i++) e_ack[i] = m_busy && cyc == m_ack && m_own == i;
      if (m_busy && cyc == m_ack) e_blk[m_own] = m_blk;
      @(negedge clk);
      if (cmp_en) begin
         check("busy", busy, m_busy && cyc > m_g);
         check("rd_en", map_rd_en, m_busy && m_read && cyc == m_g + 1);
         if (m_busy && m_read && cyc == m_g + 1) begin
            check("rd_x", map_rd_x, m_tx);
            check("rd_y", map_rd_y, m_ty);
         end
         check("ack_1", ack_1, e_ack[0]);
         check("ack_2", ack_2, e_ack[1]);
         check("blocked_1", blocked_1, e_blk[0]);
         check("blocked_2", blocked_2, e_blk[1]);
         check("pos_x_1", pos_x_1, m_x[0]);
         check("pos_y_1", pos_y_1, m_y[0]);
         check("pos_x_2", pos_x_2, m_x[1]);
         check("pos_y_2", pos_y_2, m_y[1]);
      end
      o_ack[0] = ack_1; o_ack[1] = ack_2;
      if (m_busy && cyc == m_ack) begin
         if (m_move) begin
            m_x[m_own] = m_tx; m_y[m_own] = m_ty;
            m_ready[m_own] = cyc + int'(MP);
         end
         m_busy = 0;
      end
      if (rst_v) model_reset();
   endtask

   task automatic run_until_ack(input int p, output int ack_cyc);
      ack_cyc = -1;
      for (int i = 0; i < 60; i++) begin
         step();
         if (o_ack[p]) begin
            ack_cyc = cyc;
            return;
         end
      end
      check("ack_timeout", 0, 1);
   endtask

   task automatic do_reset();
      rst_v = 1; rq = '{0, 0};
      step();
      rst_v = 0;
   endtask

   initial begin
      int t0, a, a2;
      int order[$];
      model_reset();
      foreach (map_mem[y, x]) map_mem[y][x] = EMPTY;
      map_mem[2][1] = WALL;
      rd = '{WAIT, WAIT};
      rst_v = 1; rq = '{0, 0};
      step();
      cmp_en = 1;
      step();
      rst_v = 0;
      check("rst_busy", busy, 0);
      check("rst_pos_x_2", pos_x_2, start_x_2);

      // Wall below, then an immediate move right proves no cooldown was loaded.
      rq[0] = 1; rd[0] = DOWN; t0 = cyc + 1;
      run_until_ack(0, a);
      check("wall_lat", a - t0, 3);
      check("wall_blk", blocked_1, 1);
      rd[0] = RIGHT; t0 = cyc + 1;
      run_until_ack(0, a);
      check("move_lat", a - t0, 3);
      check("move_blk", blocked_1, 0);
      // Held RIGHT: next grant waits out the cooldown, then bumps into player 2.
      run_until_ack(0, a2);
      check("cd_gap", a2 - a, MP + 3);
      check("player_blk", blocked_1, 1);
      check("player_pos_x", pos_x_1, 2);
      rq[0] = 0;
      step();

      // Edge: LEFT to x=0, then LEFT again past the edge.
      do_reset();
      rq[0] = 1; rd[0] = LEFT; t0 = cyc + 1;
      run_until_ack(0, a);
      check("left_lat", a - t0, 3);
      run_until_ack(0, a2);
`ifdef MOVE_ARB_WRAP_EN
      check("edge_gap", a2 - a, MP + 3);
      check("edge_blk", blocked_1, 0);
`else
      check("edge_gap", a2 - a, MP + 2);
      check("edge_blk", blocked_1, 1);
`endif
      rq[0] = 0;
      step();

      // Contention with WAIT moves: player 1 first, then player 2 despite player 1 re-requesting.
      do_reset();
      rq = '{1, 1}; rd = '{WAIT, WAIT};
      for (int i = 0; i < 40 && order.size() < 3; i++) begin
         step();
         if (o_ack[0]) order.push_back(1);
         if (o_ack[1]) begin order.push_back(2); rq[1] = 0; end
      end
      if (order.size() < 2) check("cont_timeout", 0, 1);
      else begin
         check("cont_first", order[0], 1);
         check("cont_second", order[1], 2);
      end
      rq[0] = 0;
      step();

      // Reset while the map read is in flight.
      rq[0] = 1; rd[0] = RIGHT;
      step();
      step();
      rq[0] = 0; rst_v = 1;
      step();
      rst_v = 0;
      step();
      check("abort_busy", busy, 0);
      check("abort_ack", ack_1, 0);
      check("abort_pos_x", pos_x_1, start_x_1);

      // Random traffic over a random map.
      foreach (map_mem[y, x]) map_mem[y][x] = ($urandom_range(0, 4) == 0) ? WALL : EMPTY;
      map_mem[start_y_1][start_x_1] = EMPTY;
      map_mem[start_y_2][start_x_2] = EMPTY;
      do_reset();
      for (int i = 0; i < 2000; i++) begin
         for (int p = 0; p < 2; p++) begin
            if (e_ack[p] || !rq[p]) begin
               rq[p] = e_ack[p] ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 3) == 0);
               rd[p] = dir_t'($urandom_range(0, 4));
            end else if (m_busy && m_own == p && $urandom_range(0, 15) == 0)
               rq[p] = 0;
         end
         step();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
